// File: rtl/timer_apb_pkg.sv
// Shared types and constants for the timer APB master arbiter.
package timer_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Timer register map on the slave side.
  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/timer_apb_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on contention the one not served last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic       gnt_idx_o,
  output logic       valid_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    valid_o   = |req_i;
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_gnt_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/timer_apb_arbiter.sv
// APB master that shares one port between two requesters and bounds each access with a pready timeout.
module timer_apb_arbiter
  import timer_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CW      = 5
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic [1:0]      req_i,
  input  logic [1:0]      wr_i,
  input  logic [1:0][7:0] addr_i,
  input  logic [1:0][7:0] wdata_i,
  output logic [1:0]      done_o,
  output logic            err_o,
  output logic [7:0]      rdata_o,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [7:0]      paddr,
  output logic [7:0]      pwdata,
  input  logic [7:0]      prdata,
  input  logic            pready,
  input  logic            pslverr
);

  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e        state_q;
  logic          gnt_q;
  logic          last_gnt_q;
  logic [CW-1:0] cnt_q;
  logic          psel_q;
  logic          penable_q;
  logic          pwrite_q;
  logic [7:0]    paddr_q;
  logic [7:0]    pwdata_q;

  logic arb_gnt;
  logic arb_valid;
  logic timeout_hit;
  logic complete;

  rr_arb2 u_arb (
    .req_i      (req_i),
    .last_gnt_i (last_gnt_q),
    .gnt_idx_o  (arb_gnt),
    .valid_o    (arb_valid)
  );

  assign timeout_hit = (TIMEOUT != 0) && !pready && (cnt_q == CNT_LAST);

  // A reset arriving mid-access abandons the transfer, so completion is masked while preset is high.
  assign complete = (state_q == ST_ACCESS) && !preset && (pready || timeout_hit);

  always_comb begin
    done_o = 2'b00;
    if (complete) done_o[gnt_q] = 1'b1;
  end

  assign err_o   = complete && (pready ? pslverr : 1'b1);
  assign rdata_o = (complete && pready) ? prdata : 8'h00;

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 8'h00;
      pwdata_q   <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q    <= ST_SETUP;
            psel_q     <= 1'b1;
            gnt_q      <= arb_gnt;
            last_gnt_q <= arb_gnt;
            pwrite_q   <= wr_i[arb_gnt];
            paddr_q    <= addr_i[arb_gnt];
            pwdata_q   <= wdata_i[arb_gnt];
            cnt_q      <= '0;
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
        end
        ST_ACCESS: begin
          if (pready || timeout_hit) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_apb_arbiter.sv
// Randomised scoreboard bench for timer_apb_arbiter with a behavioural APB slave and grant-order model.
module tb_timer_apb_arbiter;
  import timer_apb_pkg::*;

  localparam int TO = 4;

  logic            pclk = 1'b0;
  logic            preset;
  logic [1:0]      req_i, wr_i;
  logic [1:0][7:0] addr_i, wdata_i;
  logic [1:0]      done_o;
  logic            err_o;
  logic [7:0]      rdata_o;
  logic            psel, penable, pwrite;
  logic [7:0]      paddr, pwdata, prdata;
  logic            pready, pslverr;

  timer_apb_arbiter #(.TIMEOUT(TO), .CW(3)) dut (
    .pclk(pclk), .preset(preset), .req_i(req_i), .wr_i(wr_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    int         setup_cyc;
    int         done_cyc;
    bit         err;
    bit         wr;
    bit         chk_rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  typedef struct {
    int waits;
    bit err;
  } slv_t;

  exp_t       exp_q[$];
  slv_t       slv_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] smem    [256];
  bit         model_last = 1'b1;
  int         errors = 0;
  int         checks = 0;

  bit         cmd_wr    [2];
  logic [7:0] cmd_addr  [2];
  logic [7:0] cmd_wdata [2];
  int         cmd_w     [2];
  bit         cmd_e     [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_cmd(input int i, input bit wr, input logic [7:0] addr,
                         input logic [7:0] wdata, input int w, input bit e);
    cmd_wr[i] = wr; cmd_addr[i] = addr; cmd_wdata[i] = wdata; cmd_w[i] = w; cmd_e[i] = e;
  endtask

  // Reference model: a grant occupies SETUP plus (waits+1) ACCESS cycles, capped at TO by the timeout.
  task automatic plan(input int idx, input int setup, output int done);
    exp_t e;
    slv_t s;
    bit   tmo;
    tmo         = cmd_w[idx] >= TO;
    done        = setup + (tmo ? TO : cmd_w[idx] + 1);
    e.idx       = idx;
    e.setup_cyc = setup;
    e.done_cyc  = done;
    e.err       = tmo || cmd_e[idx];
    e.wr        = cmd_wr[idx];
    e.chk_rd    = !cmd_wr[idx] || tmo;
    e.addr      = cmd_addr[idx];
    e.wdata     = cmd_wdata[idx];
    e.rdata     = tmo ? 8'h00 : ref_mem[e.addr];
    if (cmd_wr[idx] && !e.err) ref_mem[e.addr] = e.wdata;
    exp_q.push_back(e);
    s.waits = cmd_w[idx];
    s.err   = cmd_e[idx];
    slv_q.push_back(s);
    model_last = idx[0];
  endtask

  task automatic wait_done(input bit [1:0] mask, input bit drop_early);
    bit [1:0] pending, seen;
    pending = mask;
    for (int c = 0; c < 64 && pending != 2'b00; c++) begin
      @(negedge pclk);
      seen = done_o & pending;
      @(posedge pclk); #1;
      if (drop_early && c == 0) req_i = 2'b00;
      req_i   = req_i & ~seen;
      pending = pending & ~seen;
    end
    check("round_completes", 32'(pending), 0);
  endtask

  task automatic run_round(input bit [1:0] mask, input bit drop_early);
    int t, d1, d2, first;
    @(posedge pclk); #1;
    t = cyc;
    if (mask == 2'b11) first = model_last ? 0 : 1;
    else               first = mask[1] ? 1 : 0;
    plan(first, t + 1, d1);
    if (mask == 2'b11) plan(1 - first, d1 + 2, d2);
    for (int i = 0; i < 2; i++) begin
      wr_i[i]    = mask[i] ? cmd_wr[i]    : 1'($urandom);
      addr_i[i]  = mask[i] ? cmd_addr[i]  : 8'($urandom);
      wdata_i[i] = mask[i] ? cmd_wdata[i] : 8'($urandom);
    end
    req_i = mask;
    wait_done(mask, drop_early);
  endtask

  task automatic reset_mid_access();
    int   t, d;
    slv_t s;
    set_cmd(0, 1'b0, ADDR_TCR, 8'h00, 1, 1'b0);
    @(posedge pclk); #1;
    t       = cyc;
    s.waits = 10;
    s.err   = 1'b0;
    slv_q.push_back(s);
    wr_i[0] = 1'b0; addr_i[0] = ADDR_TCR; wdata_i[0] = 8'h00;
    req_i   = 2'b01;
    repeat (3) begin @(posedge pclk); #1; end
    check("stalled_access", 32'({psel, penable}), 32'(2'b11));
    preset     = 1'b1;
    model_last = 1'b1;
    plan(0, t + 5, d);
    @(posedge pclk); #1;
    preset = 1'b0;
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_done", 32'(done_o), 0);
    wait_done(2'b01, 1'b0);
  endtask

  // Behavioural APB slave: wait states and pslverr come from slv_q in grant order.
  initial begin
    int   k;
    bit   in_acc;
    slv_t cur;
    in_acc = 1'b0; k = 0; cur.waits = 0; cur.err = 1'b0;
    pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
    forever begin
      @(posedge pclk); #1;
      if (psel && penable) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          k      = 0;
          if (slv_q.size() > 0) cur = slv_q.pop_front();
          else begin cur.waits = 1000; cur.err = 1'b0; end
        end else begin
          k++;
        end
        if (k == cur.waits) begin
          pready  = 1'b1;
          pslverr = cur.err;
          prdata  = pwrite ? 8'($urandom) : smem[paddr];
          if (pwrite && !cur.err) smem[paddr] = pwdata;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = 8'($urandom);
        end
      end else begin
        in_acc = 1'b0;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = 8'($urandom);
      end
    end
  end

  // Monitor: protocol stability every ACCESS cycle, scoreboard compare on each done_o.
  int         setup_seen = -1;
  logic [7:0] setup_addr, setup_wdata;
  bit         chk_idle = 1'b0;
  always @(negedge pclk) begin
    exp_t e;
    if (chk_idle) begin
      check("idle_after_done", 32'({psel, penable}), 0);
      chk_idle = 1'b0;
    end
    if (penable) check("penable_needs_psel", 32'(psel), 1);
    if (psel && !penable) begin
      setup_seen  = cyc;
      setup_addr  = paddr;
      setup_wdata = pwdata;
    end else if (psel && penable) begin
      check("paddr_stable", 32'(paddr), 32'(setup_addr));
      check("pwdata_stable", 32'(pwdata), 32'(setup_wdata));
    end
    if (done_o != 2'b00) begin
      chk_idle = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done_o), 0);
      end else begin
        e = exp_q.pop_front();
        check("done_onehot", 32'(done_o), 32'(1) << e.idx);
        check("done_cycle", cyc, e.done_cyc);
        check("setup_cycle", setup_seen, e.setup_cyc);
        check("err", 32'(err_o), 32'(e.err));
        check("paddr", 32'(paddr), 32'(e.addr));
        check("pwrite", 32'(pwrite), 32'(e.wr));
        if (e.wr)     check("pwdata", 32'(pwdata), 32'(e.wdata));
        if (e.chk_rd) check("rdata", 32'(rdata_o), 32'(e.rdata));
      end
    end
  end

  initial begin
    bit [1:0] mask;
    logic [7:0] a;
    preset = 1'b1; req_i = 2'b00; wr_i = 2'b00; addr_i = '0; wdata_i = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = 8'h00; smem[i] = 8'h00; end
    repeat (2) @(posedge pclk); #1;
    check("rst_state_psel", 32'(psel), 0);
    check("rst_state_penable", 32'(penable), 0);
    check("rst_state_pwrite", 32'(pwrite), 0);
    check("rst_state_paddr", 32'(paddr), 0);
    check("rst_state_pwdata", 32'(pwdata), 0);
    check("rst_state_done", 32'(done_o), 0);
    check("rst_state_err", 32'(err_o), 0);
    check("rst_state_rdata", 32'(rdata_o), 0);
    preset = 1'b0;

    set_cmd(0, 1'b1, ADDR_TDR, 8'hA5, 0, 1'b0); run_round(2'b01, 1'b0);
    set_cmd(0, 1'b0, ADDR_TDR, 8'h00, 0, 1'b0); run_round(2'b01, 1'b0);

    set_cmd(0, 1'b1, 8'h10, 8'h11, 0, 1'b0);
    set_cmd(1, 1'b1, 8'h20, 8'h22, 0, 1'b0); run_round(2'b11, 1'b0);
    set_cmd(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    set_cmd(1, 1'b0, 8'h20, 8'h00, 0, 1'b0); run_round(2'b11, 1'b0);

    set_cmd(1, 1'b1, ADDR_TSR, 8'h3C, 3, 1'b0);  run_round(2'b10, 1'b0);
    set_cmd(0, 1'b1, ADDR_TCR, 8'h5A, 99, 1'b0); run_round(2'b01, 1'b0);
    set_cmd(0, 1'b0, ADDR_TCR, 8'h00, 0, 1'b0);  run_round(2'b01, 1'b0);
    set_cmd(1, 1'b0, 8'hFF, 8'h00, 0, 1'b1);     run_round(2'b10, 1'b0);
    set_cmd(0, 1'b1, 8'h30, 8'h77, 1, 1'b0);     run_round(2'b01, 1'b1);

    reset_mid_access();

    for (int r = 0; r < 60; r++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        case ($urandom_range(0, 4))
          0:       a = ADDR_TDR;
          1:       a = ADDR_TCR;
          2:       a = ADDR_TSR;
          3:       a = 8'hFF;
          default: a = 8'($urandom);
        endcase
        set_cmd(i, 1'($urandom), a, 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 7) == 0);
      end
      run_round(mask, (mask != 2'b11) && ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end

    repeat (3) @(posedge pclk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
